// File: rtl/dehaze_pkg.sv
// dehaze_pkg: shared types and constants for the dehaze front-end blocks
//   state_t   : frame controller FSM states
//   PAD_VALUE : all-ones pad pixel for a given pixel width (up to 64 bits)
package dehaze_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_FLUSH, ST_DONE} state_t;

   function automatic logic [63:0] PAD_VALUE(input int w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/pos_counter.sv
// pos_counter: column/row position counter for a W x H raster
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance one pixel (col wraps at W-1 and bumps row; row wraps at H-1)
//   clr        : synchronous clear to (0,0), wins over inc
//   col, row   : current position
//   last       : position is the final pixel of the frame
module pos_counter #(
   parameter int W = 640,
   parameter int H = 480
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   input  logic                 clr,
   output logic [$clog2(W)-1:0] col,
   output logic [$clog2(H)-1:0] row,
   output logic                 last
);

   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          w_col_end;
   logic          w_row_end;

   assign w_col_end = r_col == CW'(W - 1);
   assign w_row_end = r_row == RW'(H - 1);

   // Both counters wrap at their limits so neither can overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (clr) begin
         r_col <= '0;
         r_row <= '0;
      end else if (inc) begin
         r_col <= w_col_end ? '0 : r_col + 1'b1;
         if (w_col_end)
            r_row <= w_row_end ? '0 : r_row + 1'b1;
      end
   end

   assign col  = r_col;
   assign row  = r_row;
   assign last = w_col_end & w_row_end;

endmodule

// File: rtl/min_frame_ctrl.sv
// min_frame_ctrl: frames an incoming pixel stream for a 3x3 min filter and
// appends IMG_WIDTH+2 all-ones pad pixels after each frame to flush it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_valid/s_ready     : upstream handshake, s_data pixel, s_sof frame start
//   abort               : synchronous frame abort, highest priority
//   f_valid/f_data      : registered filter input stream
//   busy                : frame in progress (streaming or flushing)
//   frame_done, sof_err : single-cycle status pulses
// Optional MIN_FRAME_CTRL_STATS_EN adds saturating frame_cnt / err_cnt outputs.
module min_frame_ctrl
   import dehaze_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_sof,
   input  logic                  abort,
   output logic                  f_valid,
   output logic [DATA_WIDTH-1:0] f_data,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  sof_err
`ifdef MIN_FRAME_CTRL_STATS_EN
   ,
   output logic [15:0]           frame_cnt,
   output logic [15:0]           err_cnt
`endif
);

   localparam int                    FW        = $clog2(IMG_WIDTH) + 1;
   localparam logic [FW-1:0]         FLUSH_LEN = FW'(IMG_WIDTH + 2);
   localparam logic [DATA_WIDTH-1:0] PAD       = DATA_WIDTH'(PAD_VALUE(DATA_WIDTH));

   state_t                        r_state;
   logic [FW-1:0]                 r_fcnt;
   logic                          r_s_ready;
   logic                          r_f_valid;
   logic [DATA_WIDTH-1:0]         r_f_data;
   logic                          r_busy;
   logic                          r_frame_done;
   logic                          r_sof_err;
   logic                          w_xfer;
   logic                          w_inc;
   logic                          w_last;
   logic [$clog2(IMG_WIDTH)-1:0]  w_col;
   logic [$clog2(IMG_HEIGHT)-1:0] w_row;
   logic                          w_unused_pos;

   assign w_xfer = s_valid & r_s_ready;

   // The sof pixel is position (0,0), so counting it leaves col=1, row=0
   assign w_inc = w_xfer & ~abort &
                  ((r_state == ST_STREAM) | ((r_state == ST_IDLE) & s_sof));

   pos_counter #(
      .W (IMG_WIDTH),
      .H (IMG_HEIGHT)
   ) u_pos (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_inc),
      .clr   (abort),
      .col   (w_col),
      .row   (w_row),
      .last  (w_last)
   );

   // Only the end-of-frame flag drives control; the raw position is not needed here
   assign w_unused_pos = ^{w_col, w_row};

   // All outputs are registered so they line up with the state they describe:
   // FLUSH covers the cycle showing the last pixel plus the IMG_WIDTH+2 pads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_fcnt       <= '0;
         r_s_ready    <= 1'b0;
         r_f_valid    <= 1'b0;
         r_f_data     <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_sof_err    <= 1'b0;
      end else begin
         r_f_valid    <= 1'b0;
         r_frame_done <= 1'b0;
         r_sof_err    <= 1'b0;
         if (abort) begin
            r_state   <= ST_IDLE;
            r_fcnt    <= '0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_s_ready <= 1'b1;
                  if (w_xfer && s_sof) begin
                     r_state   <= ST_STREAM;
                     r_busy    <= 1'b1;
                     r_f_valid <= 1'b1;
                     r_f_data  <= s_data;
                  end
               end
               ST_STREAM: begin
                  if (w_xfer) begin
                     r_f_valid <= 1'b1;
                     r_f_data  <= s_data;
                     r_sof_err <= s_sof;
                     if (w_last) begin
                        r_state   <= ST_FLUSH;
                        r_s_ready <= 1'b0;
                        r_fcnt    <= '0;
                     end
                  end
               end
               ST_FLUSH: begin
                  if (r_fcnt == FLUSH_LEN) begin
                     r_state      <= ST_DONE;
                     r_busy       <= 1'b0;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_f_valid <= 1'b1;
                     r_f_data  <= PAD;
                     r_fcnt    <= r_fcnt + 1'b1;
                  end
               end
               ST_DONE: begin
                  r_state   <= ST_IDLE;
                  r_s_ready <= 1'b1;
                  r_fcnt    <= '0;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign s_ready    = r_s_ready;
   assign f_valid    = r_f_valid;
   assign f_data     = r_f_data;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign sof_err    = r_sof_err;

`ifdef MIN_FRAME_CTRL_STATS_EN
   logic [15:0] r_frame_cnt;
   logic [15:0] r_err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (r_frame_done && r_frame_cnt != 16'hFFFF)
            r_frame_cnt <= r_frame_cnt + 1'b1;
         if (r_sof_err && r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign frame_cnt = r_frame_cnt;
   assign err_cnt   = r_err_cnt;
`endif

endmodule
